counter_bank_display: RTL and testbench

COUNTER_BANK_DISPLAY -- requirements
Module: counter_bank_display

---
 rtl/counter_bank_display.sv | 167 ++++++++++++++++
 tb/tb_counter_bank_display.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/counter_bank_display.sv
// Bank of NCH prescaled counters with per-channel tick dividers, wrap/borrow/
// saturate event pulses and a manual or auto-rotating registered display.
module counter_bank_display #(
  parameter int TICK_CYC  = 12_000_000,
  parameter int NCH       = 4,
  parameter int CW        = 8,
  parameter int ROT_TICKS = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [3:0]    step,
  input  logic [1:0]    mode,
  input  logic          clr,
  input  logic          sel_auto,
  input  logic [2:0]    sel_manual,
  output logic [CW-1:0] disp,
  output logic [2:0]    disp_ch,
  output logic [NCH-1:0] evt,
  output logic          base_tick
);

  localparam int PW = $clog2(TICK_CYC);
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_CYC - 1);
  localparam logic [7:0]    ROT_MAX = 8'(ROT_TICKS - 1);
  localparam logic [CW-1:0] CTR_MAX = {CW{1'b1}};
  localparam logic [1:0] M_UP   = 2'b00;
  localparam logic [1:0] M_DOWN = 2'b01;
  localparam logic [1:0] M_SAT  = 2'b10;

  logic [PW-1:0] pre;
  logic [PW-1:0] pre_next;
  logic [2:0]    div [NCH];
  logic [CW-1:0] ctr [NCH];
  logic [CW-1:0] ctr_next [NCH];
  logic [CW:0]   sum [NCH];
  logic [NCH-1:0] upd;
  logic [NCH-1:0] ovf;
  logic [CW-1:0] step_ext;
  logic [7:0]    rot;
  logic [2:0]    sel_clamped;
  logic [2:0]    ch_next;
  logic [CW-1:0] disp_sel;

  // Prescaler successor; base_tick is registered so it lines up with pre == PRE_MAX.
  always_comb begin
    if (pre == PRE_MAX) begin
      pre_next = {PW{1'b0}};
    end else begin
      pre_next = pre + PW'(1);
    end
  end

  // Prescaler and base tick strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      pre       <= {PW{1'b0}};
      base_tick <= 1'b0;
    end else begin
      pre       <= pre_next;
      base_tick <= (pre_next == PRE_MAX);
    end
  end

  // Per-channel next value and event for the selected mode.
  always_comb begin
    step_ext = CW'(step);
    for (int i = 0; i < NCH; i++) begin
      upd[i]      = base_tick && (div[i] == 3'(i));
      sum[i]      = {1'b0, ctr[i]} + {1'b0, step_ext};
      ctr_next[i] = ctr[i];
      ovf[i]      = 1'b0;
      case (mode)
        M_UP: begin
          ctr_next[i] = sum[i][CW-1:0];
          ovf[i]      = sum[i][CW];
        end
        M_DOWN: begin
          ctr_next[i] = ctr[i] - step_ext;
          ovf[i]      = (step_ext > ctr[i]);
        end
        M_SAT: begin
          if (sum[i][CW]) begin
            ctr_next[i] = CTR_MAX;
          end else begin
            ctr_next[i] = sum[i][CW-1:0];
          end
          ovf[i] = (ctr[i] != CTR_MAX) && (ctr_next[i] == CTR_MAX);
        end
        default: begin
          ctr_next[i] = ctr[i];
          ovf[i]      = 1'b0;
        end
      endcase
    end
  end

  // Dividers, counters and event pulses; clr wipes counters but not timing state.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        div[i] <= 3'd0;
        ctr[i] <= {CW{1'b0}};
      end
      evt <= {NCH{1'b0}};
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (base_tick) begin
          div[i] <= (div[i] == 3'(i)) ? 3'd0 : div[i] + 3'd1;
        end
        if (clr) begin
          ctr[i] <= {CW{1'b0}};
          evt[i] <= 1'b0;
        end else if (upd[i]) begin
          ctr[i] <= ctr_next[i];
          evt[i] <= ovf[i];
        end else begin
          evt[i] <= 1'b0;
        end
      end
    end
  end

  // Display channel helpers: clamped manual pick, rotation successor, value mux.
  always_comb begin
    if ({1'b0, sel_manual} >= 4'(NCH)) begin
      sel_clamped = 3'(NCH - 1);
    end else begin
      sel_clamped = sel_manual;
    end
    if (disp_ch == 3'(NCH - 1)) begin
      ch_next = 3'd0;
    end else begin
      ch_next = disp_ch + 3'd1;
    end
    disp_sel = {CW{1'b0}};
    for (int i = 0; i < NCH; i++) begin
      if (disp_ch == 3'(i)) begin
        disp_sel = ctr[i];
      end else begin
        disp_sel = disp_sel;
      end
    end
  end

  // Display selection and value; manual mode holds rot at 0 so auto resumes cleanly.
  always_ff @(posedge clk) begin
    if (rst) begin
      rot     <= 8'd0;
      disp_ch <= 3'd0;
      disp    <= {CW{1'b0}};
    end else begin
      disp <= disp_sel;
      if (!sel_auto) begin
        rot     <= 8'd0;
        disp_ch <= sel_clamped;
      end else if (base_tick) begin
        if (rot == ROT_MAX) begin
          rot     <= 8'd0;
          disp_ch <= ch_next;
        end else begin
          rot <= rot + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_counter_bank_display.sv
// Randomized and directed bench for counter_bank_display against a cycle-count
// based reference model of the tick, counter and display rules.
module tb_counter_bank_display;
  localparam int T   = 4;
  localparam int NCH = 3;
  localparam int CW  = 8;
  localparam int R   = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [3:0]    step = 4'd0;
  logic [1:0]    mode = 2'b00;
  logic          clr = 1'b0;
  logic          sel_auto = 1'b0;
  logic [2:0]    sel_manual = 3'd0;
  logic [CW-1:0] disp;
  logic [2:0]    disp_ch;
  logic [NCH-1:0] evt;
  logic          base_tick;

  int checks = 0;
  int failures = 0;

  // Reference state: cycles since reset, counter values, display state.
  int c = 0;
  int val [NCH];
  int ch = 0;
  int rot = 0;

  counter_bank_display #(.TICK_CYC(T), .NCH(NCH), .CW(CW), .ROT_TICKS(R)) dut (
    .clk(clk), .rst(rst), .step(step), .mode(mode), .clr(clr),
    .sel_auto(sel_auto), .sel_manual(sel_manual), .disp(disp),
    .disp_ch(disp_ch), .evt(evt), .base_tick(base_tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s at t=%0t got=%0h exp=%0h", tag, $time, got, exp);
    end
  endtask

  // One clock: predict from current model + inputs, clock the DUT, compare.
  task automatic cycle();
    int n_val [NCH];
    int n_evt, n_disp, n_ch, n_rot, n_c, k, s;
    bit bt;
    n_evt = 0;
    if (rst) begin
      for (int i = 0; i < NCH; i++) n_val[i] = 0;
      n_disp = 0; n_ch = 0; n_rot = 0; n_c = 0;
    end else begin
      bt = (c % T) == (T - 1);
      k = c / T + 1;
      n_disp = val[ch];
      for (int i = 0; i < NCH; i++) begin
        n_val[i] = val[i];
        if (clr) begin
          n_val[i] = 0;
        end else if (bt && (k % (i + 1) == 0)) begin
          case (mode)
            2'b00: begin
              s = val[i] + step;
              n_val[i] = s % 256;
              if (s >= 256) n_evt |= (1 << i);
            end
            2'b01: begin
              n_val[i] = (val[i] - step + 256) % 256;
              if (step > val[i]) n_evt |= (1 << i);
            end
            2'b10: begin
              s = val[i] + step;
              n_val[i] = (s > 255) ? 255 : s;
              if (val[i] < 255 && n_val[i] == 255) n_evt |= (1 << i);
            end
            default: n_val[i] = val[i];
          endcase
        end
      end
      n_ch = ch; n_rot = rot;
      if (!sel_auto) begin
        n_rot = 0;
        n_ch = (sel_manual >= NCH) ? NCH - 1 : sel_manual;
      end else if (bt) begin
        if (rot + 1 == R) begin
          n_rot = 0;
          n_ch = (ch + 1) % NCH;
        end else begin
          n_rot = rot + 1;
        end
      end
      n_c = c + 1;
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < NCH; i++) val[i] = n_val[i];
    ch = n_ch; rot = n_rot; c = n_c;
    check("disp", 32'(disp), 32'(n_disp));
    check("disp_ch", 32'(disp_ch), 32'(n_ch));
    check("evt", 32'(evt), 32'(n_evt));
    check("base_tick", 32'(base_tick), ((n_c % T) == (T - 1)) ? 32'd1 : 32'd0);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    for (int i = 0; i < NCH; i++) val[i] = 0;
    run(3);
    rst = 1'b0;
    // Plain up-count: ch0 reaches 6 after 24 cycles, shown one cycle later.
    mode = 2'b00; step = 4'd1;
    run(25);
    check("ch0_after24", 32'(disp), 32'd6);
    clr = 1'b1; run(1); clr = 1'b0;
    // Borrow down to 254, wrap up to 1, borrow to 255, then zero step.
    mode = 2'b01; step = 4'd2; run(4);
    mode = 2'b00; step = 4'd3; run(4);
    mode = 2'b01; step = 4'd2; run(4);
    step = 4'd0; run(8);
    // Saturation from 250 then a repeat update at the ceiling.
    clr = 1'b1; run(1); clr = 1'b0;
    mode = 2'b01; step = 4'd6; run(4);
    mode = 2'b10; step = 4'd8; run(4);
    run(4);
    // Clear landing exactly on an update cycle.
    mode = 2'b00; step = 4'd5;
    while ((c % T) != (T - 1)) cycle();
    clr = 1'b1; run(1); clr = 1'b0;
    run(8);
    // Manual clamp then auto rotation.
    sel_manual = 3'd5; run(2);
    check("clamp_ch", 32'(disp_ch), 32'd2);
    sel_auto = 1'b1; run(30);
    // Reset mid-prescale.
    while ((c % T) != 2) cycle();
    rst = 1'b1; run(1); rst = 1'b0;
    check("rst_disp_ch", 32'(disp_ch), 32'd0);
    run(8);
    // Random phase.
    for (int n = 0; n < 3000; n++) begin
      step = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) mode = 2'($urandom_range(0, 3));
      clr = ($urandom_range(0, 31) == 0);
      if ($urandom_range(0, 40) == 0) sel_auto = ~sel_auto;
      if ($urandom_range(0, 5) == 0) sel_manual = 3'($urandom_range(0, 7));
      rst = ($urandom_range(0, 499) == 0);
      cycle();
    end
    rst = 1'b0; clr = 1'b0;
    run(4);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
